// File: rtl/reg_read_bank_if.sv
// Signal bundle between the write-enable decoder / issue logic and the register read bank.
// The slave side is the bank itself.
interface reg_read_bank_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  reg0_en;
  logic                  reg1_en;
  logic                  reg2_en;
  logic                  reg3_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [1:0]            rs;
  logic [1:0]            rt;
  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  en_err;

  modport master (
    output reg0_en, reg1_en, reg2_en, reg3_en, wr_data,
    output rd_valid, rs, rt, op_ready,
    input  rd_ready, op_valid, op_a, op_b, en_err
  );

  modport slave (
    input  reg0_en, reg1_en, reg2_en, reg3_en, wr_data,
    input  rd_valid, rs, rt, op_ready,
    output rd_ready, op_valid, op_a, op_b, en_err
  );
endinterface

// File: rtl/reg_read_bank.sv
// Four-entry register bank with one-hot writes, write-to-read forwarding and a
// one-entry valid/ready operand buffer; multi-hot enables raise a sticky fault.
module reg_read_bank #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  reg_read_bank_if.slave bus
);

  logic [3:0]            wr_en;
  logic                  wr_single;
  logic                  wr_multi;
  logic [DATA_WIDTH-1:0] regs_q [4];
  logic [DATA_WIDTH-1:0] regs_d [4];
  logic [DATA_WIDTH-1:0] fwd    [4];
  logic                  op_valid_q, op_valid_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  en_err_q, en_err_d;
  logic                  rd_ready;
  logic                  rd_accept;

  assign wr_en     = {bus.reg3_en, bus.reg2_en, bus.reg1_en, bus.reg0_en};
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign wr_multi  = (wr_en & (wr_en - 4'd1)) != 4'd0;
  assign wr_single = (wr_en != 4'd0) && !wr_multi;

  assign rd_ready  = rst_n && (!op_valid_q || bus.op_ready);
  assign rd_accept = bus.rd_valid && rd_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (wr_single && wr_en[i]) begin
        regs_d[i] = bus.wr_data;
        fwd[i]    = bus.wr_data;
      end else begin
        regs_d[i] = regs_q[i];
        fwd[i]    = regs_q[i];
      end
    end
  end

  always_comb begin
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    en_err_d   = en_err_q | wr_multi;
    if (rd_accept) begin
      op_valid_d = 1'b1;
      op_a_d     = fwd[bus.rs];
      op_b_d     = fwd[bus.rt];
    end else if (op_valid_q && bus.op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      en_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      en_err_q   <= en_err_d;
    end
  end

  assign bus.rd_ready = rd_ready;
  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.en_err   = en_err_q;

endmodule

// File: doc/reg_read_bank.md
# reg_read_bank

Register storage and operand-read stage for the sCPU's four general-purpose registers. It holds R0–R3, which are written through the one-hot per-register write enables produced by the write-side enable decoder, plus a shared write-data bus. It serves a two-operand read port (rs/rt) through a one-entry valid/ready output buffer to the execute stage, with same-cycle write-to-read forwarding and a sticky fault flag for illegal multi-hot write enables.

## Interface
- DATA_WIDTH, 8, width of each register and of all data ports
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  reset; synchronous, active-low
- reg0_en  in  1  write enable for R0 (one-hot group with reg1_en..reg3_en)
- reg1_en  in  1  write enable for R1
- reg2_en  in  1  write enable for R2
- reg3_en  in  1  write enable for R3
- wr_data  in  DATA_WIDTH  write data, sampled when exactly one regN_en is high
- rd_valid  in  1  read request valid
- rd_ready  out  1  bank can accept a read request this cycle
- rs  in  2  source register index for operand A
- rt  in  2  source register index for operand B
- op_valid  out  1  op_a/op_b hold a valid operand pair
- op_ready  in  1  consumer accepts the operand pair
- op_a  out  DATA_WIDTH  operand A, registered
- op_b  out  DATA_WIDTH  operand B, registered
- en_err  out  1  sticky: a multi-hot write enable was seen

## Operation
- Storage: four DATA_WIDTH registers, R0..R3. R0 is an ordinary writable register, not hardwired to zero.
- Write decode: if exactly one regN_en is high on a clock edge, RN <= wr_data. If no enable is high, there is no write.
- Illegal enables: if two or more regN_en are high, no register is written and en_err is set. en_err stays set until reset.
- Read acceptance: a read is accepted on a clock edge where rd_valid && rd_ready.
- rd_ready = rst_n && (!op_valid || op_ready), i.e. combinational, so the buffer can be refilled in the same cycle it drains.
- Operand capture on acceptance: op_a <= fwd(rs), op_b <= fwd(rt), op_valid <= 1.
  - fwd(i) = wr_data if a legal single-hot write targets Ri in the same cycle; otherwise Ri.
  - A multi-hot write cycle forwards nothing; the stored value is read.
- Drain: if op_valid && op_ready and no new read is accepted, op_valid <= 0. op_a/op_b keep their last values.
- Hold: while op_valid && !op_ready, op_a/op_b/op_valid are frozen. The held pair is a snapshot and is not updated by later writes to rs/rt.
- rs == rt is legal: both operands carry the same value, including when that value is forwarded.
- Writes are independent of the read handshake. A write proceeds every cycle, including while the output is stalled.

## Timing
- Reset (rst_n low on an edge): R0..R3 = 0, op_valid = 0, op_a = op_b = 0, en_err = 0.
- While rst_n is low: rd_ready = 0, writes are ignored, and en_err is not set.
- Write latency: a register is updated at the edge where its enable is sampled. A read of that register accepted at the next edge sees the new value. A read accepted at the same edge sees it through forwarding.
- Read latency: 1 cycle. A request accepted at edge k produces op_valid = 1 with the data after edge k.
- Throughput: one read per cycle while op_ready is held high.
- Back-to-back reads: with op_ready = 1 continuously, op_valid stays high and the data changes every cycle.
- Reset mid-transfer: a pending op_valid pair is discarded, and op_valid = 0 after the reset edge.
- en_err asserts in the cycle after the first multi-hot edge.

## Test plan
- Reset/basic: hold rst_n low for 2 cycles, then release. Write R2 = 0x5A via reg2_en alone. Then read rs = 2, rt = 0.
  - Required: op_a = 0x5A, op_b = 0x00, op_valid 1 cycle after acceptance, en_err = 0.
- Forwarding: R1 = 0x11. In the same cycle, write R1 = 0x22 and read rs = 1, rt = 1.
  - Required: op_a = op_b = 0x22. R1 reads 0x22 on the next request.
- Backpressure: op_ready = 0. Read R3 (0x33), then write R3 = 0x44 and keep rd_valid high for 3 cycles.
  - Required: op_a stays 0x33 and rd_ready = 0 throughout.
  - Required: after op_ready rises, the next accepted read returns 0x44.
- Streaming: op_ready = 1, with reads rs = 0, 1, 2, 3 on consecutive cycles.
  - Required: 4 consecutive op_valid cycles with the matching stored values and no bubbles.
- Illegal enables: reg0_en = reg3_en = 1, wr_data = 0xFF, with R0 = 0x01 and R3 = 0x03.
  - Required: R0/R3 are unchanged, en_err = 1 and stays high, and a same-cycle read of R0 returns 0x01.
- Reset mid-stall: set op_valid = 1 with op_ready = 0, then pulse rst_n low for 1 edge.
  - Required: op_valid = 0, op_a = op_b = 0, all registers = 0, en_err = 0.
